ohc9_shared_adder_arbiter: RTL and testbench
============================================

# ohc9_shared_adder_arbiter

Round-robin arbiter and sequencer that shares one modulo-9 one-hot-code (OHC) residue adder between two requesters. Each requester presents a pair of 9-bit one-hot residues. The block grants one requester per cycle and performs the mod-9 addition as a cyclic rotation. It registers the result in both OHC and 4-bit binary form behind a valid/ready output handshake. It sits in the mod-9 channel of the RNS datapath, upstream of the residue-to-binary conversion stage.

## Interface
Parameters:
- none. Modulus is fixed at 9; requester count is fixed at 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 operand pair valid
- req0_ready  out  1  requester 0 operands accepted this cycle
- req0_a, req0_b  in  9 each  requester 0 OHC operands; bit k set means residue k
- req1_valid  in  1  requester 1 operand pair valid
- req1_ready  out  1  requester 1 operands accepted this cycle
- req1_a, req1_b  in  9 each  requester 1 OHC operands
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer accepts the result this cycle
- out_id  out  1  requester that produced the result
- out_ohc  out  9  (a+b) mod 9, one-hot
- out_bin  out  4  (a+b) mod 9, binary 0..8
- out_err  out  1  at least one operand was not exactly one-hot

## Operation
- Accept condition: `accept = !out_valid | out_ready`. This allows a result to be consumed and replaced in the same cycle.
- Grant selection is combinational.
  - If only one reqN_valid is high, that requester is granted.
  - If both are high, the requester selected by priority pointer `prio` is granted.
- reqN_ready = grantN & accept. It is never high for both requesters in the same cycle.
- A transfer occurs when reqN_valid & reqN_ready. On a transfer:
  - load the result register;
  - set out_valid=1 and out_id=N;
  - set prio to the other requester.
- With no transfer, prio holds its value.
- Addition: out_ohc = req_a rotated left by the index of the set bit in req_b, modulo 9 (wrap bit 8 into bit 0). out_bin is the index of the set bit in out_ohc.
- Operand check: an operand is legal only if exactly one bit is set.
  - If either operand is illegal (zero bits set or more than one bit set), set out_err=1, out_ohc=9'b0 and out_bin=4'hF.
  - An illegal operand pair is still consumed, and it still counts for round-robin.
- Output hold: out_valid & !out_ready holds all out_* signals stable.
  - Both reqN_ready outputs are 0 while the result is held.
  - Requesters must hold valid and operands stable until accepted.
- Consume without replace: out_valid & out_ready with no new transfer sets out_valid=0. Data fields hold their last value.
- States, encoded as out_valid:
  - EMPTY -> FULL on a transfer.
  - FULL -> FULL on out_ready together with a transfer.
  - FULL -> EMPTY on out_ready with no transfer.
  - FULL -> FULL (hold) on !out_ready.

## Timing
- Reset values: out_valid=0, out_id=0, out_ohc=9'b000000001, out_bin=0, out_err=0, prio=0 (requester 0 favoured first).
- Reset during operation discards any held result. The held result is not presented again after reset.
- While rst=1, reqN_ready=0.
- Latency is 1 cycle: operands accepted at edge n appear on out_* after edge n, with out_valid=1.
- Throughput is 1 result per cycle while out_ready stays high.
- When both requesters are valid continuously, grants alternate 0,1,0,1,... No requester waits more than one accepted transfer.
- reqN_ready depends combinationally on out_ready. Every other output is registered.

## Test plan
- Basic add: after reset, req0 a=9'b000000100 (2), b=9'b001000000 (6) -> next cycle out_valid=1, out_id=0, out_ohc=9'b100000000, out_bin=8, out_err=0.
- Wrap-around: req1 a=7 (9'b010000000), b=5 (9'b000100000) -> out_ohc=9'b000001000, out_bin=3. Also check 8+1 -> 0 (9'b000000001).
- Arbitration: both requesters valid every cycle with out_ready=1 for 6 cycles -> out_id sequence 0,1,0,1,0,1; reqN_ready is never high for both in the same cycle.
- Backpressure: out_ready=0 for 4 cycles with a result held -> out_* stable, both ready=0. Then raise out_ready with req0 valid -> result consumed and replaced in the same cycle; out_valid stays 1.
- Illegal input: req0 b=9'b000000000, then req0 a=9'b000010010 -> each yields out_err=1, out_ohc=0, out_bin=4'hF. The following legal op 0+0 -> out_err=0, out_bin=0.
- Reset mid-operation: assert rst for 1 cycle while out_valid=1 and out_ready=0 -> out_valid=0 and prio=0 on the next cycle. With both requesters then valid, requester 0 is granted first.

Source files
------------

// File: rtl/ohc9_shared_adder_arbiter.sv
// Two-requester round-robin front end sharing one mod-9 one-hot residue adder.
// Sum is a cyclic rotation of operand a by the index of operand b; the result is held behind valid/ready.
module ohc9_shared_adder_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [8:0] req0_a,
    input  logic [8:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [8:0] req1_a,
    input  logic [8:0] req1_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_id,
    output logic [8:0] out_ohc,
    output logic [3:0] out_bin,
    output logic       out_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e     state_q;
    logic       prio_q;
    logic       id_q;
    logic [8:0] ohc_q;
    logic [3:0] bin_q;
    logic       err_q;

    logic       accept;
    logic       grant0;
    logic       grant1;
    logic       xfer;
    logic       legal;
    logic [8:0] sel_a;
    logic [8:0] sel_b;
    logic [3:0] shift;
    logic [8:0] sum_ohc;
    logic [3:0] sum_bin;

    function automatic logic one_hot(input logic [8:0] x);
        return (x != '0) && ((x & (x - 9'd1)) == '0);
    endfunction

    function automatic logic [3:0] ohc_index(input logic [8:0] x);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned k = 0; k < 9; k++) begin
            if (x[k]) idx = 4'(k);
        end
        return idx;
    endfunction

    always_comb begin
        accept     = (state_q == EMPTY) | out_ready;
        grant0     = req0_valid & (~req1_valid | ~prio_q);
        grant1     = req1_valid & (~req0_valid | prio_q);
        req0_ready = grant0 & accept & ~rst;
        req1_ready = grant1 & accept & ~rst;
        xfer       = req0_ready | req1_ready;

        sel_a = grant1 ? req1_a : req0_a;
        sel_b = grant1 ? req1_b : req0_b;
        legal = one_hot(sel_a) & one_hot(sel_b);
        shift = ohc_index(sel_b);

        // Left rotation modulo 9: result bit m takes operand bit (m - shift) mod 9.
        sum_ohc = '0;
        for (int unsigned m = 0; m < 9; m++) begin
            sum_ohc[m] = sel_a[(m + 9 - 32'(shift)) % 9];
        end
        sum_bin = ohc_index(sum_ohc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            ohc_q   <= 9'b000000001;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (xfer) state_q <= FULL;
                end
                FULL: begin
                    if (out_ready && !xfer) state_q <= EMPTY;
                end
                default: state_q <= EMPTY;
            endcase
            if (xfer) begin
                id_q   <= grant1;
                prio_q <= grant0;
                ohc_q  <= legal ? sum_ohc : '0;
                bin_q  <= legal ? sum_bin : 4'hF;
                err_q  <= ~legal;
            end
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_id    = id_q;
    assign out_ohc   = ohc_q;
    assign out_bin   = bin_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_ohc9_shared_adder_arbiter.sv
// Directed and randomized bench for ohc9_shared_adder_arbiter against an arithmetic reference model.
module tb_ohc9_shared_adder_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       r0v, r1v, ordy;
    logic [8:0] a0, b0, a1, b1;
    logic       req0_ready, req1_ready;
    logic       out_valid, out_id, out_err;
    logic [8:0] out_ohc;
    logic [3:0] out_bin;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit       m_valid, m_id, m_err, m_prio;
    bit [8:0] m_ohc;
    bit [3:0] m_bin;
    bit       acc0, acc1;

    ohc9_shared_adder_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(r0v),
        .req0_ready(req0_ready),
        .req0_a    (a0),
        .req0_b    (b0),
        .req1_valid(r1v),
        .req1_ready(req1_ready),
        .req1_a    (a1),
        .req1_b    (b1),
        .out_valid (out_valid),
        .out_ready (ordy),
        .out_id    (out_id),
        .out_ohc   (out_ohc),
        .out_bin   (out_bin),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int residue(input bit [8:0] x);
        for (int k = 0; k < 9; k++) if (x[k]) return k;
        return 0;
    endfunction

    function automatic bit [8:0] rnd_op();
        if ($urandom_range(0, 9) == 0) return 9'($urandom);
        return 9'd1 << $urandom_range(0, 8);
    endfunction

    task automatic model_add(input bit [8:0] a, input bit [8:0] b);
        int s;
        if ($countones(a) != 1 || $countones(b) != 1) begin
            m_err = 1'b1;
            m_ohc = '0;
            m_bin = 4'hF;
        end else begin
            s     = (residue(a) + residue(b)) % 9;
            m_err = 1'b0;
            m_ohc = 9'd1 << s;
            m_bin = 4'(s);
        end
    endtask

    // One clock cycle: check ready outputs mid-cycle, advance model, check registered outputs.
    task automatic step();
        bit acc, g0, g1;
        acc  = !m_valid || ordy;
        g0   = r0v && (!r1v || !m_prio);
        g1   = r1v && (!r0v || m_prio);
        acc0 = g0 && acc && !rst;
        acc1 = g1 && acc && !rst;
        @(negedge clk);
        chk("req0_ready", 32'(req0_ready), 32'(acc0));
        chk("req1_ready", 32'(req1_ready), 32'(acc1));
        chk("ready_excl", 32'(req0_ready & req1_ready), 32'd0);
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 0; m_id = 0; m_err = 0; m_prio = 0;
            m_ohc = 9'd1; m_bin = 0;
        end else if (acc0 || acc1) begin
            if (acc1) model_add(a1, b1);
            else      model_add(a0, b0);
            m_valid = 1;
            m_id    = acc1;
            m_prio  = acc0;
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_id",    32'(out_id),    32'(m_id));
        chk("out_ohc",   32'(out_ohc),   32'(m_ohc));
        chk("out_bin",   32'(out_bin),   32'(m_bin));
        chk("out_err",   32'(out_err),   32'(m_err));
    endtask

    initial begin
        bit       exp_ids[6];
        bit       pend0, pend1;
        exp_ids = '{0, 1, 0, 1, 0, 1};
        rst = 1; r0v = 0; r1v = 0; ordy = 1;
        a0 = 9'd1; b0 = 9'd1; a1 = 9'd1; b1 = 9'd1;
        m_valid = 0; m_id = 0; m_err = 0; m_prio = 0; m_ohc = 9'd1; m_bin = 0;
        step(); step();
        chk("reset_ohc", 32'(out_ohc), 32'h001);
        chk("reset_valid", 32'(out_valid), 32'd0);
        rst = 0;

        // Basic add 2+6
        r0v = 1; a0 = 9'b000000100; b0 = 9'b001000000;
        step(); r0v = 0;
        chk("basic_ohc", 32'(out_ohc), 32'h100);
        chk("basic_bin", 32'(out_bin), 32'd8);
        chk("basic_id", 32'(out_id), 32'd0);

        // Wrap 7+5 from requester 1
        r1v = 1; a1 = 9'b010000000; b1 = 9'b000100000;
        step(); r1v = 0;
        chk("wrap_ohc", 32'(out_ohc), 32'h008);
        chk("wrap_bin", 32'(out_bin), 32'd3);
        chk("wrap_id", 32'(out_id), 32'd1);

        // Arbitration with both valid
        r0v = 1; r1v = 1; a1 = 9'd4; b1 = 9'd8;
        a0 = 9'd2; b0 = 9'd1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("arb_id", 32'(out_id), 32'(exp_ids[i]));
        end
        r1v = 0;

        // Backpressure with req0 waiting, operands 8+1
        ordy = 0; a0 = 9'h100; b0 = 9'h002;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_id", 32'(out_id), 32'd1);
        end
        ordy = 1;
        step(); r0v = 0;
        chk("replace_valid", 32'(out_valid), 32'd1);
        chk("wrap0_ohc", 32'(out_ohc), 32'h001);
        chk("wrap0_bin", 32'(out_bin), 32'd0);

        // Illegal operands
        r0v = 1; a0 = 9'h001; b0 = 9'h000;
        step();
        chk("ill_zero_err", 32'(out_err), 32'd1);
        chk("ill_zero_bin", 32'(out_bin), 32'hF);
        a0 = 9'b000010010; b0 = 9'h001;
        step();
        chk("ill_multi_err", 32'(out_err), 32'd1);
        chk("ill_multi_ohc", 32'(out_ohc), 32'h000);
        a0 = 9'h001; b0 = 9'h001;
        step(); r0v = 0;
        chk("legal_after_err", 32'(out_err), 32'd0);
        chk("legal_after_bin", 32'(out_bin), 32'd0);

        // Consume without replace, then reset while a result is held
        step();
        r0v = 1; a0 = 9'd2; b0 = 9'd2;
        step(); r0v = 0;
        ordy = 0; rst = 1;
        step(); rst = 0;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        ordy = 1; r0v = 1; r1v = 1;
        step();
        chk("rst_first_grant", 32'(out_id), 32'd0);
        r0v = 0; r1v = 0;
        step();

        // Randomized traffic honouring the hold-until-accepted rule
        pend0 = 0; pend1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pend0 && $urandom_range(0, 9) < 7) begin pend0 = 1; a0 = rnd_op(); b0 = rnd_op(); end
            if (!pend1 && $urandom_range(0, 9) < 7) begin pend1 = 1; a1 = rnd_op(); b1 = rnd_op(); end
            r0v  = pend0;
            r1v  = pend1;
            ordy = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 99) == 0);
            step();
            if (acc0) pend0 = 0;
            if (acc1) pend1 = 0;
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
